mbox_req_arb: RTL and testbench

- Two-requester arbiter and sequencer for the MBOX memory port.
- Requester 0 is the EBOX (VMA, read/write/PSE). Requester 1 is the channel/refill path.
- Grants one request at a time, drives the MBOX port, waits for completion, and returns data and a response strobe to the owner.
- A watchdog flags non-existent memory (NXM) when a cycle never completes.

---
 rtl/mbox_req_arb_if.sv | 48 ++++
 rtl/mbox_req_arb.sv | 144 ++++++++++++++
 tb/tb_mbox_req_arb.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbox_req_arb_if.sv
// Bundle of EBOX/channel request signals and the MBOX memory port seen by mbox_req_arb.
// The slave modport is the arbiter's view; master is the requesters plus memory side.
interface mbox_req_arb_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 36
);
  logic              eboxReq;
  logic              eboxRead;
  logic              eboxWrite;
  logic              eboxPSE;
  logic [ADDR_W-1:0] eboxVMA;
  logic [DATA_W-1:0] eboxWData;
  logic              chanReq;
  logic              chanWrite;
  logic [ADDR_W-1:0] chanAdr;
  logic [DATA_W-1:0] chanWData;
  logic              memReq;
  logic              memRead;
  logic              memWrite;
  logic              memPSE;
  logic [ADDR_W-1:0] memAdr;
  logic [DATA_W-1:0] memWData;
  logic              memDone;
  logic [DATA_W-1:0] memRData;
  logic              eboxResp;
  logic              chanResp;
  logic [DATA_W-1:0] rData;
  logic              nxmErr;
  logic              nxmClr;
  logic              busy;
  logic              owner;

  modport slave (
    input  eboxReq, eboxRead, eboxWrite, eboxPSE, eboxVMA, eboxWData,
    input  chanReq, chanWrite, chanAdr, chanWData,
    input  memDone, memRData, nxmClr,
    output memReq, memRead, memWrite, memPSE, memAdr, memWData,
    output eboxResp, chanResp, rData, nxmErr, busy, owner
  );

  modport master (
    output eboxReq, eboxRead, eboxWrite, eboxPSE, eboxVMA, eboxWData,
    output chanReq, chanWrite, chanAdr, chanWData,
    output memDone, memRData, nxmClr,
    input  memReq, memRead, memWrite, memPSE, memAdr, memWData,
    input  eboxResp, chanResp, rData, nxmErr, busy, owner
  );
endinterface

// File: rtl/mbox_req_arb.sv
// Two-requester (EBOX / channel) arbiter and sequencer for the MBOX memory port,
// with a per-cycle watchdog that reports non-existent memory.
module mbox_req_arb #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 36,
  parameter int TIMEOUT  = 255,
  parameter int EBOX_PRI = 1
) (
  input  logic clk,
  input  logic resetN,
  mbox_req_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        timer;
  logic              rr_ptr;   // 1 = channel is favoured on the next tie
  logic              pick_chan;

  logic              mem_req;
  logic              mem_read;
  logic              mem_write;
  logic              mem_pse;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic              ebox_resp;
  logic              chan_resp;
  logic [DATA_W-1:0] r_data;
  logic              nxm_err;
  logic              busy_q;
  logic              owner_q;

  always_comb begin
    pick_chan = 1'b0;
    if (bus.chanReq && !bus.eboxReq)
      pick_chan = 1'b1;
    else if (bus.chanReq && bus.eboxReq && EBOX_PRI == 0)
      pick_chan = rr_ptr;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= S_IDLE;
      timer     <= '0;
      rr_ptr    <= 1'b0;
      mem_req   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_pse   <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      ebox_resp <= 1'b0;
      chan_resp <= 1'b0;
      r_data    <= '0;
      nxm_err   <= 1'b0;
      busy_q    <= 1'b0;
      owner_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make these one-cycle strobes; a later
      // assignment in the same block overrides them for this edge only.
      mem_req   <= 1'b0;
      ebox_resp <= 1'b0;
      chan_resp <= 1'b0;
      if (bus.nxmClr)
        nxm_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.eboxReq || bus.chanReq) begin
            state   <= S_WAIT;
            timer   <= '0;
            mem_req <= 1'b1;
            busy_q  <= 1'b1;
            owner_q <= pick_chan;
            if (pick_chan) begin
              mem_adr   <= bus.chanAdr;
              mem_wdata <= bus.chanWData;
              mem_read  <= ~bus.chanWrite;
              mem_write <= bus.chanWrite;
              mem_pse   <= 1'b0;
            end else begin
              mem_adr   <= bus.eboxVMA;
              mem_wdata <= bus.eboxWData;
              mem_read  <= bus.eboxRead;
              mem_write <= bus.eboxWrite;
              mem_pse   <= bus.eboxPSE;
            end
          end
        end

        S_WAIT: begin
          // Completion takes precedence over a watchdog expiring on the same edge.
          if (bus.memDone) begin
            if (mem_read)
              r_data <= bus.memRData;
            state     <= S_RESP;
            ebox_resp <= ~owner_q;
            chan_resp <= owner_q;
          end else if (timer == TMO_LAST) begin
            nxm_err   <= 1'b1;
            r_data    <= '0;
            state     <= S_RESP;
            ebox_resp <= ~owner_q;
            chan_resp <= owner_q;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        S_RESP: begin
          busy_q    <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          mem_pse   <= 1'b0;
          rr_ptr    <= ~owner_q;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.memReq   = mem_req;
  assign bus.memRead  = mem_read;
  assign bus.memWrite = mem_write;
  assign bus.memPSE   = mem_pse;
  assign bus.memAdr   = mem_adr;
  assign bus.memWData = mem_wdata;
  assign bus.eboxResp = ebox_resp;
  assign bus.chanResp = chan_resp;
  assign bus.rData    = r_data;
  assign bus.nxmErr   = nxm_err;
  assign bus.busy     = busy_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_mbox_req_arb.sv
// Directed bench for mbox_req_arb: a fixed-priority and a round-robin instance
// share the same stimulus and are checked against hand-computed expectations.
module tb_mbox_req_arb;

  localparam logic [22:0] EB_ADR = 23'h000123;
  localparam logic [22:0] CH_ADR = 23'h000456;
  localparam logic [35:0] EB_WD  = 36'h9ABCDEF01;
  localparam logic [35:0] CH_WD  = 36'h123456789;
  localparam logic [35:0] R1     = 36'o123456701234;
  localparam logic [35:0] R2     = 36'o765432107654;
  localparam logic [35:0] R3     = 36'h0A5A5A5A5;
  localparam logic [35:0] JUNK   = 36'hFFFFFFFFF;
  localparam int          NV     = 22;

  typedef struct packed {
    logic        mreq;
    logic        busy;
    logic        owner;
    logic        eresp;
    logic        cresp;
    logic        nxm;
    logic [2:0]  typ;    // {memPSE, memWrite, memRead}
    logic [22:0] adr;
    logic [35:0] wdata;
    logic [35:0] rdata;
  } obs_t;

  typedef struct packed {
    logic [1:0]  req;    // {chanReq, eboxReq}
    logic [2:0]  etyp;   // {eboxPSE, eboxWrite, eboxRead}
    logic        cwr;
    logic        done;
    logic [35:0] rdin;
    logic        mreq;
    logic        busy;
    logic        own;
    logic [1:0]  resp;   // {chanResp, eboxResp}
    logic [2:0]  typ;
    logic [35:0] rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic        ebox_req, ebox_read, ebox_write, ebox_pse;
  logic        chan_req, chan_write;
  logic        mem_done, nxm_clr;
  logic [35:0] mem_rdata;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cnt_pri = 0;
  int   cnt_rr = 0;
  vec_t vecs [NV];
  obs_t obs_pri, obs_rr;

  always #5 clk = ~clk;

  mbox_req_arb_if #(.ADDR_W(23), .DATA_W(36)) if_pri ();
  mbox_req_arb_if #(.ADDR_W(23), .DATA_W(36)) if_rr ();

  mbox_req_arb #(.ADDR_W(23), .DATA_W(36), .TIMEOUT(8), .EBOX_PRI(1)) dut_pri (
    .clk(clk), .resetN(resetN), .bus(if_pri.slave));
  mbox_req_arb #(.ADDR_W(23), .DATA_W(36), .TIMEOUT(8), .EBOX_PRI(0)) dut_rr (
    .clk(clk), .resetN(resetN), .bus(if_rr.slave));

  assign if_pri.eboxReq   = ebox_req;   assign if_rr.eboxReq   = ebox_req;
  assign if_pri.eboxRead  = ebox_read;  assign if_rr.eboxRead  = ebox_read;
  assign if_pri.eboxWrite = ebox_write; assign if_rr.eboxWrite = ebox_write;
  assign if_pri.eboxPSE   = ebox_pse;   assign if_rr.eboxPSE   = ebox_pse;
  assign if_pri.eboxVMA   = EB_ADR;     assign if_rr.eboxVMA   = EB_ADR;
  assign if_pri.eboxWData = EB_WD;      assign if_rr.eboxWData = EB_WD;
  assign if_pri.chanReq   = chan_req;   assign if_rr.chanReq   = chan_req;
  assign if_pri.chanWrite = chan_write; assign if_rr.chanWrite = chan_write;
  assign if_pri.chanAdr   = CH_ADR;     assign if_rr.chanAdr   = CH_ADR;
  assign if_pri.chanWData = CH_WD;      assign if_rr.chanWData = CH_WD;
  assign if_pri.memDone   = mem_done;   assign if_rr.memDone   = mem_done;
  assign if_pri.memRData  = mem_rdata;  assign if_rr.memRData  = mem_rdata;
  assign if_pri.nxmClr    = nxm_clr;    assign if_rr.nxmClr    = nxm_clr;

  assign obs_pri = {if_pri.memReq, if_pri.busy, if_pri.owner, if_pri.eboxResp, if_pri.chanResp,
                    if_pri.nxmErr, if_pri.memPSE, if_pri.memWrite, if_pri.memRead,
                    if_pri.memAdr, if_pri.memWData, if_pri.rData};
  assign obs_rr  = {if_rr.memReq, if_rr.busy, if_rr.owner, if_rr.eboxResp, if_rr.chanResp,
                    if_rr.nxmErr, if_rr.memPSE, if_rr.memWrite, if_rr.memRead,
                    if_rr.memAdr, if_rr.memWData, if_rr.rData};

  function automatic vec_t mk(logic [1:0] req, logic [2:0] et, logic cwr, logic done,
                              logic [35:0] rdin, logic mreq, logic busy, logic own,
                              logic [1:0] resp, logic [2:0] typ, logic [35:0] rdata);
    vec_t v;
    v.req = req;   v.etyp = et;   v.cwr = cwr;   v.done = done; v.rdin = rdin;
    v.mreq = mreq; v.busy = busy; v.own = own;   v.resp = resp; v.typ = typ;
    v.rdata = rdata;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(string tag, obs_t o, logic mreq, logic busy, logic own,
                           logic [1:0] resp, logic nxm, logic [2:0] typ, logic [35:0] rdata);
    check({tag, ".memReq"},   64'(o.mreq),  64'(mreq));
    check({tag, ".busy"},     64'(o.busy),  64'(busy));
    check({tag, ".owner"},    64'(o.owner), 64'(own));
    check({tag, ".eboxResp"}, 64'(o.eresp), 64'(resp[0]));
    check({tag, ".chanResp"}, 64'(o.cresp), 64'(resp[1]));
    check({tag, ".nxmErr"},   64'(o.nxm),   64'(nxm));
    check({tag, ".type"},     64'(o.typ),   64'(typ));
    check({tag, ".rData"},    64'(o.rdata), 64'(rdata));
    if (busy) begin
      check({tag, ".memAdr"},   64'(o.adr),   64'(own ? CH_ADR : EB_ADR));
      check({tag, ".memWData"}, 64'(o.wdata), 64'(own ? CH_WD : EB_WD));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (obs_pri.eresp || obs_pri.cresp) cnt_pri++;
    if (obs_rr.eresp || obs_rr.cresp) cnt_rr++;
  endtask

  task automatic idle_inputs();
    ebox_req = 1'b0; ebox_read = 1'b0; ebox_write = 1'b0; ebox_pse = 1'b0;
    chan_req = 1'b0; chan_write = 1'b0; mem_done = 1'b0; nxm_clr = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // req   etyp    cwr  done rdin | mreq busy own resp   typ     rdata
    vecs[0]  = mk(2'b11, 3'b001, '1, '0, '0,   '1, '1, '0, 2'b00, 3'b001, '0);
    vecs[1]  = mk(2'b11, 3'b001, '1, '1, R1,   '0, '1, '0, 2'b01, 3'b001, R1);
    vecs[2]  = mk(2'b11, 3'b001, '1, '0, '0,   '0, '0, '0, 2'b00, 3'b000, R1);
    vecs[3]  = mk(2'b10, 3'b000, '1, '0, '0,   '1, '1, '1, 2'b00, 3'b010, R1);
    vecs[4]  = mk(2'b10, 3'b000, '1, '1, JUNK, '0, '1, '1, 2'b10, 3'b010, R1);
    vecs[5]  = mk(2'b10, 3'b000, '1, '1, JUNK, '0, '0, '1, 2'b00, 3'b000, R1);
    vecs[6]  = mk(2'b00, 3'b000, '0, '0, '0,   '0, '0, '1, 2'b00, 3'b000, R1);
    vecs[7]  = mk(2'b01, 3'b001, '0, '0, '0,   '1, '1, '0, 2'b00, 3'b001, R1);
    vecs[8]  = mk(2'b01, 3'b001, '0, '0, '0,   '0, '1, '0, 2'b00, 3'b001, R1);
    vecs[9]  = mk(2'b01, 3'b001, '0, '0, '0,   '0, '1, '0, 2'b00, 3'b001, R1);
    vecs[10] = mk(2'b01, 3'b001, '0, '0, '0,   '0, '1, '0, 2'b00, 3'b001, R1);
    vecs[11] = mk(2'b01, 3'b001, '0, '1, R2,   '0, '1, '0, 2'b01, 3'b001, R2);
    vecs[12] = mk(2'b01, 3'b001, '0, '0, '0,   '0, '0, '0, 2'b00, 3'b000, R2);
    vecs[13] = mk(2'b00, 3'b000, '0, '1, JUNK, '0, '0, '0, 2'b00, 3'b000, R2);
    vecs[14] = mk(2'b01, 3'b000, '0, '0, '0,   '1, '1, '0, 2'b00, 3'b000, R2);
    vecs[15] = mk(2'b01, 3'b000, '0, '1, JUNK, '0, '1, '0, 2'b01, 3'b000, R2);
    vecs[16] = mk(2'b01, 3'b000, '0, '0, '0,   '0, '0, '0, 2'b00, 3'b000, R2);
    vecs[17] = mk(2'b00, 3'b000, '0, '0, '0,   '0, '0, '0, 2'b00, 3'b000, R2);
    vecs[18] = mk(2'b01, 3'b110, '0, '0, '0,   '1, '1, '0, 2'b00, 3'b110, R2);
    vecs[19] = mk(2'b01, 3'b110, '0, '1, JUNK, '0, '1, '0, 2'b01, 3'b110, R2);
    vecs[20] = mk(2'b01, 3'b110, '0, '0, '0,   '0, '0, '0, 2'b00, 3'b000, R2);
    vecs[21] = mk(2'b00, 3'b000, '0, '0, '0,   '0, '0, '0, 2'b00, 3'b000, R2);

    idle_inputs();
    resetN = 1'b0;
    tick();
    tick();
    check_obs("reset.pri", obs_pri, '0, '0, '0, 2'b00, '0, 3'b000, '0);
    check_obs("reset.rr",  obs_rr,  '0, '0, '0, 2'b00, '0, 3'b000, '0);
    check("reset.memAdr",   64'(obs_pri.adr),   64'(0));
    check("reset.memWData", 64'(obs_rr.wdata),  64'(0));
    resetN = 1'b1;

    // Table: tie under both policies (post-reset), single read, no-type and write+PSE cycles.
    for (int i = 0; i < NV; i++) begin
      ebox_req = vecs[i].req[0];
      chan_req = vecs[i].req[1];
      {ebox_pse, ebox_write, ebox_read} = vecs[i].etyp;
      chan_write = vecs[i].cwr;
      mem_done   = vecs[i].done;
      mem_rdata  = vecs[i].rdin;
      tick();
      check_obs($sformatf("v%0d.pri", i), obs_pri, vecs[i].mreq, vecs[i].busy, vecs[i].own,
                vecs[i].resp, '0, vecs[i].typ, vecs[i].rdata);
      check_obs($sformatf("v%0d.rr", i), obs_rr, vecs[i].mreq, vecs[i].busy, vecs[i].own,
                vecs[i].resp, '0, vecs[i].typ, vecs[i].rdata);
    end
    idle_inputs();

    // Both requesters held for four transactions after a fresh reset.
    resetN = 1'b0;
    #1;
    tick();
    resetN = 1'b1;
    cnt_pri = 0;
    cnt_rr  = 0;
    ebox_req = 1'b1; ebox_read = 1'b1; chan_req = 1'b1; chan_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int w;
      w = 0;
      while (!obs_rr.mreq && w < 6) begin
        tick();
        w++;
      end
      check($sformatf("rr%0d.grant", i), 64'(obs_rr.mreq), 64'(1));
      check($sformatf("rr%0d.owner", i), 64'(obs_rr.owner), 64'(i % 2));
      check($sformatf("rr%0d.memAdr", i), 64'(obs_rr.adr), 64'((i % 2) ? CH_ADR : EB_ADR));
      check($sformatf("pri%0d.owner", i), 64'(obs_pri.owner), 64'(0));
      mem_done  = 1'b1;
      mem_rdata = R1 + 36'(i);
      tick();
      mem_done = 1'b0;
      check($sformatf("rr%0d.eboxResp", i), 64'(obs_rr.eresp), 64'((i % 2) == 0));
      check($sformatf("rr%0d.chanResp", i), 64'(obs_rr.cresp), 64'((i % 2) == 1));
      check($sformatf("rr%0d.rData", i),    64'(obs_rr.rdata), 64'(R1 + 36'(i)));
      if (i == 3) begin
        ebox_req = 1'b0;
        chan_req = 1'b0;
      end
    end
    repeat (3) tick();
    check("rr.resp_count",  64'(cnt_rr),  64'(4));
    check("pri.resp_count", 64'(cnt_pri), 64'(4));
    check("rr.idle_busy",   64'(obs_rr.busy), 64'(0));
    idle_inputs();

    // Channel write that never completes: NXM after eight cycles, then clear.
    chan_req = 1'b1; chan_write = 1'b1;
    tick();
    check("tmo1.memReq", 64'(obs_pri.mreq), 64'(1));
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("tmo1.wait%0d.nxm", k), 64'(obs_pri.nxm), 64'(0));
      check($sformatf("tmo1.wait%0d.busy", k), 64'(obs_rr.busy), 64'(1));
    end
    tick();
    chan_req = 1'b0;
    check_obs("tmo1.pri", obs_pri, '0, '1, '1, 2'b10, '1, 3'b010, '0);
    check_obs("tmo1.rr",  obs_rr,  '0, '1, '1, 2'b10, '1, 3'b010, '0);
    tick();
    check("tmo1.sticky", 64'(obs_pri.nxm), 64'(1));
    nxm_clr = 1'b1;
    tick();
    nxm_clr = 1'b0;
    check("tmo1.clr.pri", 64'(obs_pri.nxm), 64'(0));
    check("tmo1.clr.rr",  64'(obs_rr.nxm),  64'(0));

    // Clear asserted on the very cycle the next timeout fires: set must win.
    chan_req = 1'b1;
    tick();
    repeat (7) tick();
    nxm_clr = 1'b1;
    tick();
    nxm_clr = 1'b0;
    chan_req = 1'b0;
    check("tmo2.setwins.pri", 64'(obs_pri.nxm), 64'(1));
    check("tmo2.setwins.rr",  64'(obs_rr.nxm),  64'(1));
    check("tmo2.chanResp",    64'(obs_pri.cresp), 64'(1));
    tick();
    nxm_clr = 1'b1;
    tick();
    nxm_clr = 1'b0;
    check("tmo2.clr", 64'(obs_pri.nxm), 64'(0));
    idle_inputs();

    // memDone on the final watchdog cycle completes normally.
    ebox_req = 1'b1; ebox_read = 1'b1;
    tick();
    check("edge.memReq", 64'(obs_pri.mreq), 64'(1));
    repeat (7) tick();
    mem_done  = 1'b1;
    mem_rdata = R3;
    tick();
    mem_done = 1'b0;
    ebox_req = 1'b0;
    check_obs("edge.pri", obs_pri, '0, '1, '0, 2'b01, '0, 3'b001, R3);
    check_obs("edge.rr",  obs_rr,  '0, '1, '0, 2'b01, '0, 3'b001, R3);
    repeat (2) tick();
    idle_inputs();

    // Reset pulsed during WAIT: outputs drop at once, no response, then normal service.
    ebox_req = 1'b1; ebox_read = 1'b1;
    tick();
    check("rst.grant", 64'(obs_pri.mreq), 64'(1));
    tick();
    #2;
    resetN = 1'b0;
    #1;
    check_obs("rst.now.pri", obs_pri, '0, '0, '0, 2'b00, '0, 3'b000, '0);
    check_obs("rst.now.rr",  obs_rr,  '0, '0, '0, 2'b00, '0, 3'b000, '0);
    check("rst.now.memAdr", 64'(obs_pri.adr), 64'(0));
    cnt_pri = 0;
    tick();
    check("rst.held.eboxResp", 64'(obs_pri.eresp), 64'(0));
    resetN = 1'b1;
    tick();
    check("rst.regrant.pri", 64'(obs_pri.mreq), 64'(1));
    check("rst.regrant.rr",  64'(obs_rr.mreq),  64'(1));
    mem_done  = 1'b1;
    mem_rdata = R2;
    tick();
    mem_done = 1'b0;
    ebox_req = 1'b0;
    check_obs("rst.resp.pri", obs_pri, '0, '1, '0, 2'b01, '0, 3'b001, R2);
    repeat (2) tick();
    check("rst.resp_count", 64'(cnt_pri), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
